// File: rtl/mult_r1_if.sv
// Handshake and data bundle for the iterative multiplier.
// Ports: start/is_signed/inA/inB request a multiply; busy/done/out report progress and result.
// master = requester side, slave = multiplier side.
interface mult_r1_if #(
    parameter int BIT_WIDTH = 32
);
    logic                     start;
    logic                     is_signed;
    logic [BIT_WIDTH-1:0]     inA;
    logic [BIT_WIDTH-1:0]     inB;
    logic                     busy;
    logic                     done;
    logic [2*BIT_WIDTH-1:0]   out;

    modport master (
        output start, is_signed, inA, inB,
        input  busy, done, out
    );

    modport slave (
        input  start, is_signed, inA, inB,
        output busy, done, out
    );
endinterface

// File: rtl/mult_r1.sv
// Iterative radix-2 shift-add multiplier (signed/unsigned), one multiplier bit per clock.
// Latency: done pulses in the single FIN cycle, BIT_WIDTH+1 cycles after the accepting edge.
// Backpressure: start is ignored while busy; start held in FIN re-launches with no idle bubble.
// Ports: clk, rst (sync, active-high), bus (slave side of mult_r1_if).
module mult_r1 #(
    parameter int BIT_WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mult_r1_if.slave  bus
);
    localparam int W  = BIT_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;

    logic [2*W-1:0]    mcand;      // multiplicand magnitude, shifted left each RUN cycle
    logic [W-1:0]      mplier;     // multiplier magnitude, shifted right each RUN cycle
    logic [2*W-1:0]    acc;        // unsigned partial product
    logic [2*W-1:0]    acc_nxt;
    logic [CW-1:0]     cnt;
    logic              sign;
    logic [2*W-1:0]    out_q;

    logic [W-1:0]      mag_a;
    logic [W-1:0]      mag_b;

    // Two's-complement negate of the most-negative value yields 2^(W-1),
    // which is exact when read back as a W-bit unsigned magnitude.
    always_comb begin
        mag_a = bus.inA;
        mag_b = bus.inB;
        if (bus.is_signed && bus.inA[W-1]) mag_a = -bus.inA;
        if (bus.is_signed && bus.inB[W-1]) mag_b = -bus.inB;
    end

    assign last    = (cnt == CW'(W - 1));
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = FIN;
            end
            FIN: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            out_q  <= '0;
        end else if (accept) begin
            mcand  <= {{W{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            sign   <= bus.is_signed & (bus.inA[W-1] ^ bus.inB[W-1]);
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            // Result register only moves on the final step, so partial
            // products never reach the output.
            if (last) out_q <= sign ? -acc_nxt : acc_nxt;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == FIN);
    assign bus.out  = out_q;
endmodule

// File: tb/tb_mult_r1.sv
// Self-checking bench for mult_r1 (BIT_WIDTH=32) with an expected-result queue.
module tb_mult_r1;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_r1_if #(.BIT_WIDTH(W)) bus ();

    mult_r1 #(.BIT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q [$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] e;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] p;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            p  = sa * sb;
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        return p;
    endfunction

    // Caller is positioned just after a negedge; start is seen at the next posedge.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
        bus.start     = 1'b1;
        bus.inA       = a;
        bus.inB       = b;
        bus.is_signed = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles, output bit ok);
        cycles = 0;
        busy_cycles = 0;
        ok = 1'b0;
        while (cycles < 200 && !ok) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
            if (bus.done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.inA = '0;
        bus.inB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_checks++;
        if (bus.out !== 64'h0) begin n_fail++; $display("FAIL reset_out got=%h want=0", bus.out); end
        // reset must win over a same-cycle start
        bus.start = 1'b1;
        bus.inA = 32'd3;
        bus.inB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority busy got=%b want=0", bus.busy); end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    // Starts in the very first cycle after reset release.
    task automatic test_basic();
        int c, b;
        bit ok;
        logic [63:0] e;
        drive_start(32'd3, 32'd5, 1'b0, 64'h000000000000000F);
        wait_done(c, b, ok);
        n_checks++;
        if (!ok || c != 33) begin n_fail++; $display("FAIL basic_latency got=%0d ok=%0d want=33", c, ok); end
        n_checks++;
        if (b != 32) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=32", b); end
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out !== e) begin n_fail++; $display("FAIL basic_out got=%h want=%h", bus.out, e); end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
        n_checks++;
        if (bus.out !== 64'hF) begin n_fail++; $display("FAIL basic_out_hold got=%h want=%h", bus.out, 64'hF); end
    endtask

    task automatic test_patterns();
        vec_t tbl [0:10];
        int c, b;
        bit ok;
        logic [63:0] e;
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
        tbl[5] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};
        tbl[6] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        for (int i = 7; i < 11; i++) begin
            tbl[i].a = $urandom;
            tbl[i].b = $urandom;
            tbl[i].s = 1'($urandom_range(0, 1));
            tbl[i].e = model(tbl[i].a, tbl[i].b, tbl[i].s);
        end
        for (int i = 0; i < 11; i++) begin
            drive_start(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e);
            wait_done(c, b, ok);
            n_checks++;
            if (!ok || c != 33) begin n_fail++; $display("FAIL pattern%0d_latency got=%0d ok=%0d want=33", i, c, ok); end
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out !== e) begin n_fail++; $display("FAIL pattern%0d_out got=%h want=%h", i, bus.out, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        int done_cyc = 0;
        logic [63:0] out_at_done = '0;
        logic [63:0] e;
        drive_start(32'd7, 32'd9, 1'b0, 64'h3F);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    out_at_done = bus.out;
                end
            end
            if (cyc == 5) begin
                bus.start = 1'b1;
                bus.inA = 32'd2;
                bus.inB = 32'd2;
            end else begin
                bus.start = 1'b0;
                bus.inA = $urandom;
                bus.inB = $urandom;
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
        n_checks++;
        if (done_cyc != 33) begin n_fail++; $display("FAIL ignore_latency got=%0d want=33", done_cyc); end
        e = exp_q.pop_front();
        n_checks++;
        if (out_at_done !== e) begin n_fail++; $display("FAIL ignore_out got=%h want=%h", out_at_done, e); end
    endtask

    task automatic test_reset_mid_run();
        int c, b;
        bit ok;
        logic [63:0] e;
        drive_start(32'd100, 32'd200, 1'b0, model(32'd100, 32'd200, 1'b0));
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got=%b want=1", bus.busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        n_checks++;
        if (bus.out !== 64'h0) begin n_fail++; $display("FAIL midrst_out got=%h want=0", bus.out); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b want=0", bus.done); end
        drive_start(32'd6, 32'd7, 1'b0, 64'h2A);
        wait_done(c, b, ok);
        n_checks++;
        if (!ok || c != 33) begin n_fail++; $display("FAIL midrst_latency got=%0d ok=%0d want=33", c, ok); end
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out !== e) begin n_fail++; $display("FAIL midrst_out2 got=%h want=%h", bus.out, e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c, b;
        bit ok;
        int cyc = 0;
        int held_err = 0;
        bit first_busy = 1'b0;
        logic [63:0] first;
        logic [63:0] e;
        drive_start(32'd11, 32'd13, 1'b0, 64'd143);
        wait_done(c, b, ok);
        e = exp_q.pop_front();
        first = bus.out;
        n_checks++;
        if (!ok || first !== e) begin n_fail++; $display("FAIL b2b_first_out got=%h ok=%0d want=%h", first, ok, e); end
        // still in FIN: start held here re-launches directly
        drive_start(32'hFFFFFFEF, 32'd19, 1'b1, 64'hFFFFFFFFFFFFFEBD);
        ok = 1'b0;
        while (cyc < 200 && !ok) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first_busy = bus.busy;
            if (bus.done) ok = 1'b1;
            else if (bus.out !== first) held_err++;
        end
        n_checks++;
        if (first_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble busy=%b want=1", first_busy); end
        n_checks++;
        if (held_err != 0) begin n_fail++; $display("FAIL b2b_hold got=%0d changes want=0", held_err); end
        n_checks++;
        if (!ok || cyc != 33) begin n_fail++; $display("FAIL b2b_latency got=%0d ok=%0d want=33", cyc, ok); end
        e = exp_q.pop_front();
        n_checks++;
        if (bus.out !== e) begin n_fail++; $display("FAIL b2b_second_out got=%h want=%h", bus.out, e); end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.inA = '0;
        bus.inB = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_r1.md
MULT_R1 -- requirements
Module: mult_r1

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new multiply; sampled only when busy=0.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start.
REQ-006 SHALL have port inA  input  BIT_WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port inB  input  BIT_WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse; out is valid and final.
REQ-010 SHALL have port out  output  2*BIT_WIDTH  product, registered, held until the next accepted start.

Function
REQ-011 SHALL implement an iterative radix-2 shift-add multiplier, one multiplier bit per clock, with states IDLE, RUN, FIN.
REQ-012 SHALL accept start only in IDLE or FIN; start in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-013 On acceptance SHALL:
- latch |inA| and |inB| (magnitude when is_signed=1, raw value otherwise);
- latch the result sign = is_signed & (inA[MSB] ^ inB[MSB]);
- clear the partial product and iteration counter;
- enter RUN.
REQ-014 SHALL, in each RUN cycle, add the shifted multiplicand to the partial product when the current multiplier bit is 1, then advance the counter.
REQ-015 SHALL leave RUN after exactly BIT_WIDTH RUN cycles, entering FIN.
REQ-016 SHALL apply sign correction on the RUN->FIN edge: out = sign ? -(unsigned product) : unsigned product, computed modulo 2^(2*BIT_WIDTH).
REQ-017 SHALL handle magnitude of the most-negative operand (e.g. 0x80000000) as 2^(BIT_WIDTH-1) without overflow, using an internal width of at least BIT_WIDTH bits unsigned.
REQ-018 SHALL assert done for exactly the one cycle spent in FIN, i.e. BIT_WIDTH+1 cycles after the edge that accepted start.
REQ-019 SHALL return from FIN to IDLE unless start=1 in FIN, in which case it re-enters RUN directly (back-to-back, no idle bubble).
REQ-020 SHALL hold busy=1 in RUN only; busy=0 in IDLE and FIN.
REQ-021 SHALL update out only on the RUN->FIN edge; out SHALL NOT show partial products.
REQ-022 SHALL produce a result that depends only on the values sampled at acceptance; input changes during RUN SHALL have no effect.
REQ-023 SHALL treat a zero operand like any other value: full BIT_WIDTH-cycle latency and out=0, with no early termination.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, force state=IDLE, busy=0, done=0, out=0, and clear the counter and internal operands.
REQ-025 SHALL give rst priority over start, including in the same cycle.
REQ-026 SHALL, when rst is asserted mid-RUN, abandon the operation with no done pulse and no update of out.
REQ-027 SHALL accept a start in the first cycle after rst deasserts.

Verification
REQ-028 SHALL cover: BIT_WIDTH=32, unsigned 3*5 -> done exactly 33 cycles after start edge, out=0x000000000000000F, busy high for 32 cycles.
REQ-029 SHALL cover: signed 0xFFFFFFFF*0x00000001 -> out=0xFFFFFFFFFFFFFFFF; unsigned same operands -> out=0x00000000FFFFFFFF.
REQ-030 SHALL cover: unsigned 0xFFFFFFFF*0xFFFFFFFF -> out=0xFFFFFFFE00000001; signed 0x80000000*0x80000000 -> out=0x4000000000000000; signed 0x80000000*0x00000001 -> out=0xFFFFFFFF80000000.
REQ-031 SHALL cover: start 7*9, then start 2*2 pulsed mid-RUN with inA/inB toggled -> single done, out=0x3F.
REQ-032 SHALL cover: rst asserted at RUN cycle 10 -> busy=0, out=0, no done; new start 6*7 next cycle -> out=0x2A after 33 cycles.
REQ-033 SHALL cover: back-to-back start held in FIN -> second done exactly 33 cycles after first done; first result held until then.
